// File: rtl/dmem_stall_pkg.sv
// Shared types and constants for the data-memory stall controller.
// Used by dmem_stall_ctrl (optional feature: DMEM_READY_EN).
package dmem_stall_pkg;

   localparam int LAT_W      = 4;
   localparam int RD_LAT_DEF = 1;
   localparam int WR_LAT_DEF = 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_e;

endpackage

// File: rtl/dmem_stall_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones.
// Used for the stall-cycle performance counter.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage stall controller for a fixed- or handshake-latency data memory.
// Define DMEM_READY_EN to end stalls on mem_ready with a timeout instead.
module dmem_stall_ctrl
   import dmem_stall_pkg::*;
#(
   parameter int RD_LAT  = RD_LAT_DEF,
   parameter int WR_LAT  = WR_LAT_DEF,
   parameter int PERF_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              flush,
   output logic              MemStall,
   output logic              mem_req,
   output logic              mem_we,
`ifdef DMEM_READY_EN
   input  logic              mem_ready,
   output logic              timeout_err,
`endif
   output logic [PERF_W-1:0] stall_cycles
);

   state_e           state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic [LAT_W-1:0] lat;
   logic             stall, req, we;

   // Stores win when both strobes are set.
   assign lat = MemWrite ? LAT_W'(WR_LAT) : LAT_W'(RD_LAT);

`ifdef DMEM_READY_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_err;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      req     = 1'b0;
      we      = 1'b0;
`ifdef DMEM_READY_EN
      tmo_d   = tmo_q;
      tmo_err = 1'b0;
`endif
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (MemRead | MemWrite) begin
                  req = 1'b1;
                  we  = MemWrite;
`ifdef DMEM_READY_EN
                  stall   = 1'b1;
                  tmo_d   = '0;
                  state_d = mem_ready ? DONE : WAIT;
`else
                  if (lat != '0) begin
                     stall   = 1'b1;
                     cnt_d   = lat - LAT_W'(1);
                     state_d = (lat > LAT_W'(1)) ? WAIT : DONE;
                  end
`endif
               end
            end
            WAIT: begin
               stall = 1'b1;
`ifdef DMEM_READY_EN
               if (mem_ready) begin
                  state_d = DONE;
               end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  tmo_err = 1'b1;
                  state_d = DONE;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
`else
               cnt_d = cnt_q - LAT_W'(1);
               if (cnt_q == LAT_W'(1)) begin
                  state_d = DONE;
               end
`endif
            end
            // The stalled instruction is still presented here.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef DMEM_READY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign timeout_err = reset_n & tmo_err;
`endif

   // Outputs are forced low while reset is held, whatever the inputs do.
   assign MemStall = reset_n & stall;
   assign mem_req  = reset_n & req;
   assign mem_we   = reset_n & we;

   sat_counter #(
      .W(PERF_W)
   ) u_perf (
      .clk    (clk),
      .reset_n(reset_n),
      .inc    (MemStall),
      .count  (stall_cycles)
   );

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Scoreboard bench: two controller instances with different latencies
// driven by shared random and directed stimulus.
module tb_dmem_stall_ctrl;

   localparam int PW = 4;

   typedef struct packed {
      logic          stall;
      logic          req;
      logic          we;
      logic [PW-1:0] cnt;
   } exp_t;

   typedef struct packed {
      exp_t a;
      exp_t b;
   } pair_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic MemRead = 1'b0;
   logic MemWrite = 1'b0;
   logic flush = 1'b0;

   logic          a_stall, a_req, a_we;
   logic [PW-1:0] a_cnt;
   logic          b_stall, b_req, b_we;
   logic [PW-1:0] b_cnt;

   pair_t sb[$];
   pair_t mon_e;
   int    n_chk = 0;
   int    n_pass = 0;

   // Latencies: index 0 -> u_a, index 1 -> u_b.
   int rl[2] = '{0, 1};
   int wl[2] = '{3, 2};
   int busy[2] = '{0, 0};
   int skip[2] = '{0, 0};
   int perf[2] = '{0, 0};

   always #5 clk = ~clk;

   dmem_stall_ctrl #(
      .RD_LAT(0), .WR_LAT(3), .PERF_W(PW), .TIMEOUT(8)
   ) u_a (
      .clk(clk), .reset_n(rst_n), .MemRead(MemRead),
      .MemWrite(MemWrite), .flush(flush), .MemStall(a_stall),
      .mem_req(a_req), .mem_we(a_we), .stall_cycles(a_cnt)
   );

   dmem_stall_ctrl #(
      .RD_LAT(1), .WR_LAT(2), .PERF_W(PW), .TIMEOUT(8)
   ) u_b (
      .clk(clk), .reset_n(rst_n), .MemRead(MemRead),
      .MemWrite(MemWrite), .flush(flush), .MemStall(b_stall),
      .mem_req(b_req), .mem_we(b_we), .stall_cycles(b_cnt)
   );

   // Reference: busy = stall cycles still owed, skip = one ignored cycle.
   task automatic step(input logic r, input logic w,
                       input logic f, input logic rs);
      pair_t e;
      exp_t  x;
      int    lat;
      @(posedge clk);
      #1;
      rst_n    = rs;
      MemRead  = r;
      MemWrite = w;
      flush    = f;
      for (int i = 0; i < 2; i++) begin
         x = '0;
         if (!rs) begin
            busy[i] = 0;
            skip[i] = 0;
            perf[i] = 0;
         end else begin
            x.cnt = PW'(perf[i]);
            if (f) begin
               busy[i] = 0;
               skip[i] = 0;
            end else if (busy[i] > 0) begin
               x.stall = 1'b1;
               busy[i]--;
               if (busy[i] == 0) skip[i] = 1;
            end else if (skip[i] != 0) begin
               skip[i] = 0;
            end else if (r | w) begin
               x.req = 1'b1;
               x.we  = w;
               lat   = w ? wl[i] : rl[i];
               if (lat > 0) begin
                  x.stall = 1'b1;
                  busy[i] = lat - 1;
                  if (busy[i] == 0) skip[i] = 1;
               end
            end
            if (x.stall && perf[i] < (2**PW) - 1) perf[i]++;
         end
         if (i == 0) e.a = x;
         else e.b = x;
      end
      sb.push_back(e);
   endtask

   task automatic check(input string nm, input exp_t act, input exp_t exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s t=%0t stall/req/we/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                  nm, $time, act.stall, act.req, act.we, act.cnt,
                  exp.stall, exp.req, exp.we, exp.cnt);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("u_a", {a_stall, a_req, a_we, a_cnt}, mon_e.a);
         check("u_b", {b_stall, b_req, b_we, b_cnt}, mon_e.b);
      end
   end

   initial begin
      logic r, w, f, rs;
      // Reset with live inputs: outputs must stay low.
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      // Load held two cycles.
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      step(0, 0, 0, 1);
      // Store held four cycles.
      repeat (4) step(0, 1, 0, 1);
      step(0, 0, 0, 1);
      // Flush in the second stall cycle.
      step(0, 1, 0, 1);
      step(0, 1, 1, 1);
      step(0, 0, 0, 1);
      // Back-to-back load then store, both strobes together.
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      step(1, 1, 0, 1);
      step(1, 1, 0, 1);
      step(1, 1, 0, 1);
      step(1, 1, 0, 1);
      step(0, 0, 0, 1);
      // Reset mid-stall, then release with a load held.
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      step(1, 0, 0, 0);
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      step(0, 0, 0, 1);
      // Random traffic; strobes held while either instance stalls.
      r = 1'b0;
      w = 1'b0;
      for (int k = 0; k < 500; k++) begin
         if (busy[0] == 0 && busy[1] == 0) begin
            r = ($urandom_range(0, 2) != 0);
            w = ($urandom_range(0, 2) == 0);
         end
         f  = ($urandom_range(0, 15) == 0);
         rs = ($urandom_range(0, 79) != 0);
         step(r, w, f, rs);
      end
      step(0, 0, 0, 1);
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         n_chk++;
         $display("FAIL drain queue=%0d want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
